// File: rtl/alu_wb_pkg.sv
`default_nettype none
// ============================================================================
// alu_wb_pkg : writeback kind encodings, FSM states and R15 address
// Revision   : 1.0
// ============================================================================
package alu_wb_pkg;

  typedef enum logic [1:0] {
    WB_NONE   = 2'd0,
    WB_SINGLE = 2'd1,
    WB_MUL    = 2'd2,
    WB_DIV    = 2'd3
  } wb_kind_t;

  localparam logic [3:0] R15_ADDR = 4'hF;

  typedef logic [1:0] wb_state_t;
  localparam wb_state_t IDLE   = 2'd0;
  localparam wb_state_t WR_R15 = 2'd1;
  localparam wb_state_t EXC    = 2'd2;

  localparam int EXC_CNT_W = 8;

  function automatic logic wb_two_writes(input wb_kind_t kind);
    return (kind == WB_MUL) || (kind == WB_DIV);
  endfunction

  function automatic logic wb_has_write(input wb_kind_t kind);
    return kind != WB_NONE;
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_writeback_if.sv
`default_nettype none
// ============================================================================
// alu_writeback_if : ALU result handshake bus (ALU = master, writeback = slave)
// Revision         : 1.0
// ============================================================================
interface alu_writeback_if
  import alu_wb_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int REG_ADDR_W = 4
) ();

  logic                    inValid;
  logic                    inReady;
  logic [2*DATA_W-1:0]     aluRslt;
  logic [DATA_W-1:0]       aluRsltR15;
  logic                    ovExcep;
  wb_kind_t                wbKind;
  logic [REG_ADDR_W-1:0]   destAddr;
  logic [DATA_W-1:0]       pcIn;

  modport master (
    output inValid, aluRslt, aluRsltR15, ovExcep, wbKind, destAddr, pcIn,
    input  inReady
  );

  modport slave (
    input  inValid, aluRslt, aluRsltR15, ovExcep, wbKind, destAddr, pcIn,
    output inReady
  );

endinterface
`default_nettype wire

// File: rtl/alu_writeback.sv
`default_nettype none
// ============================================================================
// alu_writeback : sequences ALU results onto the single register-file write
//                 port (op1 then R15) and captures overflow exceptions.
// Option        : ALU_WB_EXC_CNT_EN enables the saturating overflow counter.
// Revision      : 1.0
// ============================================================================
module alu_writeback
  import alu_wb_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int REG_ADDR_W = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  alu_writeback_if.slave        res,
  output logic                  rfWe,
  output logic [REG_ADDR_W-1:0] rfWaddr,
  output logic [DATA_W-1:0]     rfWdata,
  output logic                  excValid,
  input  logic                  excAck,
  output logic [DATA_W-1:0]     epc,
  output logic                  busy,
  output logic [EXC_CNT_W-1:0]  excCount
);

  localparam logic [REG_ADDR_W-1:0] c_r15_addr = '1;

  wb_state_t         r_state;
  logic [DATA_W-1:0] r_r15_data;

  logic              w_xfer;
  logic              w_first_wr;
  logic              w_goto_r15;
  logic [DATA_W-1:0] w_first_data;
  logic [DATA_W-1:0] w_r15_data;

  assign res.inReady = (r_state == IDLE);
  assign busy        = (r_state != IDLE);
  assign w_xfer      = res.inValid && res.inReady;

  // Overflow suppresses every register write for this result.
  always_comb begin
    w_first_wr   = 1'b0;
    w_goto_r15   = 1'b0;
    w_first_data = res.aluRslt[DATA_W-1:0];
    w_r15_data   = res.aluRsltR15;
    if (!res.ovExcep) begin
      w_first_wr = wb_has_write(res.wbKind);
      w_goto_r15 = wb_two_writes(res.wbKind);
      if (res.wbKind == WB_DIV) begin
        w_first_data = res.aluRsltR15;
        w_r15_data   = res.aluRslt[2*DATA_W-1:DATA_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_xfer) begin
            if (res.ovExcep) begin
              r_state <= EXC;
            end else if (w_goto_r15) begin
              r_state <= WR_R15;
            end
          end
        end
        WR_R15: begin
          r_state <= IDLE;
        end
        EXC: begin
          if (excAck) begin
            r_state <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rfWe    <= 1'b0;
      rfWaddr <= '0;
      rfWdata <= '0;
    end else begin
      rfWe <= 1'b0;
      if (r_state == WR_R15) begin
        rfWe    <= 1'b1;
        rfWaddr <= c_r15_addr;
        rfWdata <= r_r15_data;
      end else if (w_xfer && w_first_wr) begin
        rfWe    <= 1'b1;
        rfWaddr <= res.destAddr;
        rfWdata <= w_first_data;
      end
    end
  end

  // Second-write value is held only across the WR_R15 cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_r15_data <= '0;
    end else if (w_xfer && w_goto_r15) begin
      r_r15_data <= w_r15_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      excValid <= 1'b0;
      epc      <= '0;
    end else if (w_xfer && res.ovExcep) begin
      excValid <= 1'b1;
      epc      <= res.pcIn;
    end else if ((r_state == EXC) && excAck) begin
      excValid <= 1'b0;
    end
  end

`ifdef ALU_WB_EXC_CNT_EN
  logic [EXC_CNT_W-1:0] r_exc_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_exc_count <= '0;
    end else if (w_xfer && res.ovExcep && (r_exc_count != {EXC_CNT_W{1'b1}})) begin
      r_exc_count <= r_exc_count + 1'b1;
    end
  end

  assign excCount = r_exc_count;
`else
  assign excCount = '0;
`endif

endmodule
`default_nettype wire
